// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce FSM,
// single-cycle strobe per accepted press, optional auto-repeat while held.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse,
  output logic level,
  output logic held
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_RELEASE_CHK
  } state_t;

  logic [1:0]        r_sync;
  state_t            r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_pulse;
  logic              r_level;
  logic              r_held;

  state_t            w_state_next;
  logic [DB_W-1:0]   w_db_next;
  logic [HOLD_W-1:0] w_hold_next;
  logic              w_pulse_next;
  logic              w_level_next;
  logic              w_held_next;
  logic              w_s;
  logic              w_rep_hit;

  // Synchroniser resets to "released" so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], key_n};
    end
  end

  assign w_s       = r_sync[1];
  assign w_rep_hit = r_held ? (r_hold_cnt == RATE_LAST) : (r_hold_cnt == DELAY_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RELEASED;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_pulse    <= 1'b0;
      r_level    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_db_cnt   <= w_db_next;
      r_hold_cnt <= w_hold_next;
      r_pulse    <= w_pulse_next;
      r_level    <= w_level_next;
      r_held     <= w_held_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_db_next    = r_db_cnt;
    w_hold_next  = r_hold_cnt;
    w_pulse_next = 1'b0;
    w_level_next = r_level;
    w_held_next  = r_held;
    case (r_state)
      ST_RELEASED: begin
        if (!w_s) begin
          w_state_next = ST_PRESS_CHK;
          w_db_next    = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (w_s) begin
          w_state_next = ST_RELEASED;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next = ST_PRESSED;
          w_pulse_next = 1'b1;
          w_level_next = 1'b1;
          w_hold_next  = '0;
        end else begin
          w_db_next = r_db_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it always beats a coincident repeat.
        if (w_s) begin
          w_state_next = ST_RELEASE_CHK;
          w_db_next    = '0;
        end else if (REPEAT_EN != 0) begin
          if (w_rep_hit) begin
            // With tiny delay/rate values, wait one cycle rather than strobe back-to-back.
            if (!r_pulse) begin
              w_pulse_next = 1'b1;
              w_held_next  = 1'b1;
              w_hold_next  = '0;
            end
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
      end
      ST_RELEASE_CHK: begin
        if (!w_s) begin
          w_state_next = ST_PRESSED;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next = ST_RELEASED;
          w_level_next = 1'b0;
          w_held_next  = 1'b0;
          w_hold_next  = '0;
        end else begin
          w_db_next = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RELEASED;
      end
    endcase
  end

  assign pulse = r_pulse;
  assign level = r_level;
  assign held  = r_held;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench: two instances (repeat off / on) share clk, rst and key_n;
// per-edge outputs are captured into bit masks and compared against hand-derived masks.
module tb_key_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_n = 1'b1;
  logic p0, l0, h0, p1, l1, h1;

  int checks = 0;
  int failures = 0;

  logic [63:0] mp0, ml0, mh0, mp1, ml1, mh1;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEBOUNCE_CYC(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut_norep (
    .clk(clk), .rst(rst), .key_n(key_n), .pulse(p0), .level(l0), .held(h0)
  );

  key_debounce_pulse #(
    .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut_rep (
    .clk(clk), .rst(rst), .key_n(key_n), .pulse(p1), .level(l1), .held(h1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] at(input int i);
    return 64'd1 << i;
  endfunction

  // pat[e] is the key_n value sampled at edge e; rst is released before edge 0.
  task automatic play(input logic [63:0] pat, input int n);
    mp0 = '0; ml0 = '0; mh0 = '0; mp1 = '0; ml1 = '0; mh1 = '0;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      key_n = pat[e];
      rst = 1'b1;
      @(posedge clk);
      #1;
      mp0[e] = p0; ml0[e] = l0; mh0[e] = h0;
      mp1[e] = p1; ml1[e] = l1; mh1[e] = h1;
    end
  endtask

  task automatic hold_reset(input logic k);
    @(negedge clk);
    key_n = k;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with key pressed, then release reset while still pressed
    hold_reset(1'b0);
    chk("t1_reset_outs", {58'd0, p0, l0, h0, p1, l1, h1}, 64'd0);
    play(64'd0, 12);
    chk("t1_pulse_norep", mp0, at(6));
    chk("t1_pulse_rep", mp1, at(6));
    chk("t1_level", ml0, rng(6, 11));
    chk("t1_held_rep", mh1, 64'd0);
    $display("test1 reset-then-press: pulse mask %h", mp0);

    // 2: held 40 cycles then released
    hold_reset(1'b1);
    play(rng(40, 63), 50);
    chk("t2_pulse_norep", mp0, at(6));
    chk("t2_level_norep", ml0, rng(6, 45));
    chk("t2_held_norep", mh0, 64'd0);
    chk("t2_pulse_rep", mp1, at(6) | at(26) | at(34));
    chk("t2_held_rep", mh1, rng(26, 45));
    chk("t2_level_rep", ml1, rng(6, 45));
    $display("test2 hold40-release: norep %h rep %h", mp0, mp1);

    // 3: bouncing press
    hold_reset(1'b1);
    play(64'h28, 20);
    chk("t3_pulse_norep", mp0, at(12));
    chk("t3_pulse_rep", mp1, at(12));
    chk("t3_level", ml0, rng(12, 19));
    $display("test3 bounce: pulse mask %h", mp0);

    // 4: two-sample release glitch while pressed freezes the hold count
    hold_reset(1'b1);
    play(rng(12, 13), 31);
    chk("t4_level_norep", ml0, rng(6, 30));
    chk("t4_pulse_norep", mp0, at(6));
    chk("t4_pulse_rep", mp1, at(6) | at(29));
    chk("t4_held_rep", mh1, rng(29, 30));
    chk("t4_level_rep", ml1, rng(6, 30));
    $display("test4 release-glitch: rep pulse mask %h", mp1);

    // 5: auto-repeat over 60 cycles
    hold_reset(1'b1);
    play(64'd0, 60);
    chk("t5_pulse_rep", mp1, at(6) | at(26) | at(34) | at(42) | at(50) | at(58));
    chk("t5_held_rep", mh1, rng(26, 59));
    chk("t5_pulse_norep", mp0, at(6));
    chk("t5_held_norep", mh0, 64'd0);
    $display("test5 auto-repeat: rep pulse mask %h", mp1);

    // 6a: reset during PRESS_CHK discards the partial debounce
    hold_reset(1'b1);
    play(64'd0, 4);
    #1 rst = 1'b0;
    #1;
    play(64'd0, 12);
    chk("t6a_pulse_norep", mp0, at(6));
    chk("t6a_level_rep", ml1, rng(6, 11));
    $display("test6a reset in debounce: pulse mask %h", mp0);

    // 6b: reset right after a repeat pulse with held=1
    hold_reset(1'b0);
    play(64'd0, 27);
    chk("t6b_pre_pulse", mp1, at(6) | at(26));
    chk("t6b_pre_held", mh1, at(26));
    #1 rst = 1'b0;
    #1;
    chk("t6b_async_drop", {61'd0, p1, l1, h1}, 64'd0);
    play(64'd0, 8);
    chk("t6b_post_pulse", mp1, at(6));
    chk("t6b_post_level", ml1, rng(6, 7));
    chk("t6b_post_held", mh1, 64'd0);
    $display("test6b reset while held: post pulse mask %h", mp1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
